uart_rx_buffer: RTL and testbench



---
 rtl/i2c_bridge_pkg.sv | 14 +
 rtl/byte_fifo.sv | 75 +++++++
 rtl/uart_rx_buffer.sv | 81 ++++++++
 tb/tb_uart_rx_buffer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/i2c_bridge_pkg.sv
// Shared definitions for the UART-to-I2C bridge: byte width, receive buffer depth
// and the encodings of the receive-buffer ingest FSM.
package i2c_bridge_pkg;

    localparam int unsigned UART_DATA_W       = 8;
    localparam int unsigned RX_BUF_DEPTH_LOG2 = 4;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAck     = 2'd1,
        StWaitLow = 2'd2
    } ingest_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Power-of-two byte FIFO with show-ahead read, occupancy count and push/pop on the
// same edge. A push while full is accepted only when a pop frees a slot that edge.
module byte_fifo import i2c_bridge_pkg::*; #(
    parameter int unsigned DATA_W     = UART_DATA_W,
    parameter int unsigned DEPTH_LOG2 = RX_BUF_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_W-1:0]     push_data,
    output logic                  push_accept,
    input  logic                  pop,
    output logic [DATA_W-1:0]     rd_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CountOne = 1;
    localparam logic [DEPTH_LOG2:0]   CountMax = (DEPTH_LOG2 + 1)'(Depth);
    localparam logic [DEPTH_LOG2-1:0] PtrOne   = 1;

    logic [DATA_W-1:0]     mem_q [Depth];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push, do_pop;

    assign full    = (count_q == CountMax);
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    // A pop on the same edge frees the slot the write lands in.
    assign do_push = push && (!full || do_pop);

    assign push_accept = do_push;
    assign rd_data     = mem_q[rd_ptr_q];
    assign count       = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CountOne;
            2'b01:   count_d = count_q - CountOne;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// Buffers bytes from the UART receiver for the command controller: captures each
// level-signalled byte once, acknowledges it, and flags bytes dropped while full.
module uart_rx_buffer import i2c_bridge_pkg::*; #(
    parameter int unsigned DATA_W     = UART_DATA_W,
    parameter int unsigned DEPTH_LOG2 = RX_BUF_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     i_rx_data,
    input  logic                  i_rx_ready,
    output logic                  o_rx_ack,
    output logic [DATA_W-1:0]     o_data,
    output logic                  o_data_ready,
    input  logic                  i_data_ack,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_overflow,
    input  logic                  i_clr_overflow
);

    ingest_state_e state_q, state_d;
    logic          rx_ack_q;
    logic          overflow_q, overflow_d;
    logic          push, push_accept, drop;
    logic          fifo_full, fifo_empty;

    byte_fifo #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_byte_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_data   (i_rx_data),
        .push_accept (push_accept),
        .pop         (i_data_ack),
        .rd_data     (o_data),
        .count       (o_count),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

    assign push = (state_q == StIdle) && i_rx_ready;
    // Only a full FIFO refuses a push, so any refused capture is a drop.
    assign drop = push && !push_accept && fifo_full;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (i_rx_ready) state_d = StAck;
            StAck:     state_d = StWaitLow;
            StWaitLow: if (!i_rx_ready) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (i_clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            rx_ack_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_ack_q   <= (state_d == StAck);
            overflow_q <= overflow_d;
        end
    end

    assign o_rx_ack     = rx_ack_q;
    assign o_overflow   = overflow_q;
    assign o_data_ready = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer: single byte, ordering with wrap, overflow,
// push/pop at full, held ready, empty pop and reset mid-stream.
module tb_uart_rx_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] i_rx_data;
    logic       i_rx_ready;
    logic       o_rx_ack;
    logic [7:0] o_data;
    logic       o_data_ready;
    logic       i_data_ack;
    logic [4:0] o_count;
    logic       o_overflow;
    logic       i_clr_overflow;

    int n_vec = 0;
    int n_err = 0;
    int ack_cnt = 0;

    uart_rx_buffer dut (
        .clk            (clk),
        .reset          (reset),
        .i_rx_data      (i_rx_data),
        .i_rx_ready     (i_rx_ready),
        .o_rx_ack       (o_rx_ack),
        .o_data         (o_data),
        .o_data_ready   (o_data_ready),
        .i_data_ack     (i_data_ack),
        .o_count        (o_count),
        .o_overflow     (o_overflow),
        .i_clr_overflow (i_clr_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_rx_ack) ack_cnt <= ack_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the ingest FSM back in idle.
    task automatic send_byte(input logic [7:0] b);
        bit got;
        got        = 1'b0;
        i_rx_data  = b;
        i_rx_ready = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (o_rx_ack) got = 1'b1;
        end
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        i_rx_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic pop_byte(output logic [7:0] b);
        b          = o_data;
        i_data_ack = 1'b1;
        @(negedge clk);
        i_data_ack = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        int a0;

        reset          = 1'b1;
        i_rx_data      = '0;
        i_rx_ready     = 1'b0;
        i_data_ack     = 1'b0;
        i_clr_overflow = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_ready", 32'(o_data_ready), 32'd0);
        check("rst_ack", 32'(o_rx_ack), 32'd0);
        check("rst_ovf", 32'(o_overflow), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single byte
        a0 = ack_cnt;
        send_byte(8'hA5);
        check("single_acks", 32'(ack_cnt - a0), 32'd1);
        check("single_ready", 32'(o_data_ready), 32'd1);
        check("single_data", 32'(o_data), 32'hA5);
        check("single_count", 32'(o_count), 32'd1);
        pop_byte(b);
        check("single_pop", 32'(b), 32'hA5);
        check("single_count0", 32'(o_count), 32'd0);
        check("single_ready0", 32'(o_data_ready), 32'd0);

        // Ordering across pointer wrap
        for (int i = 0; i < 8; i++) send_byte(8'(i));
        for (int i = 0; i < 4; i++) begin
            pop_byte(b);
            check("order_a", 32'(b), 32'(i));
        end
        for (int i = 8; i < 20; i++) send_byte(8'(i));
        check("order_count16", 32'(o_count), 32'd16);
        for (int i = 4; i < 20; i++) begin
            pop_byte(b);
            check("order_b", 32'(b), 32'(i));
        end
        check("order_ovf", 32'(o_overflow), 32'd0);
        check("order_count0", 32'(o_count), 32'd0);

        // Full and overflow
        a0 = ack_cnt;
        for (int i = 0; i < 17; i++) send_byte(8'(8'h30 + i));
        check("full_count", 32'(o_count), 32'd16);
        check("full_ovf", 32'(o_overflow), 32'd1);
        check("full_head", 32'(o_data), 32'h30);
        check("full_acks", 32'(ack_cnt - a0), 32'd17);
        i_clr_overflow = 1'b1;
        @(negedge clk);
        i_clr_overflow = 1'b0;
        check("clr_ovf", 32'(o_overflow), 32'd0);
        check("clr_count", 32'(o_count), 32'd16);

        // Push and pop on the same edge while full
        i_rx_data  = 8'h5A;
        i_rx_ready = 1'b1;
        i_data_ack = 1'b1;
        @(negedge clk);
        i_data_ack = 1'b0;
        check("pp_ack", 32'(o_rx_ack), 32'd1);
        check("pp_count", 32'(o_count), 32'd16);
        check("pp_ovf", 32'(o_overflow), 32'd0);
        check("pp_head", 32'(o_data), 32'h31);
        i_rx_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            pop_byte(b);
            check("pp_drain", 32'(b), 32'(8'h31 + i));
        end
        pop_byte(b);
        check("pp_last", 32'(b), 32'h5A);
        check("pp_count0", 32'(o_count), 32'd0);

        // Ready held high for many cycles
        a0         = ack_cnt;
        i_rx_data  = 8'h77;
        i_rx_ready = 1'b1;
        repeat (10) @(negedge clk);
        i_rx_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("held_acks", 32'(ack_cnt - a0), 32'd1);
        check("held_count", 32'(o_count), 32'd1);
        pop_byte(b);
        check("held_data", 32'(b), 32'h77);

        // Pop while empty
        i_data_ack = 1'b1;
        @(negedge clk);
        i_data_ack = 1'b0;
        @(negedge clk);
        check("empty_pop_count", 32'(o_count), 32'd0);
        check("empty_pop_ready", 32'(o_data_ready), 32'd0);

        // Reset with five bytes stored and the FSM waiting for ready low
        for (int i = 0; i < 4; i++) send_byte(8'(8'h40 + i));
        i_rx_data  = 8'h44;
        i_rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mid_count5", 32'(o_count), 32'd5);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_count", 32'(o_count), 32'd0);
        check("mid_rst_ready", 32'(o_data_ready), 32'd0);
        check("mid_rst_ovf", 32'(o_overflow), 32'd0);
        check("mid_rst_ack", 32'(o_rx_ack), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("recap_count", 32'(o_count), 32'd1);
        check("recap_data", 32'(o_data), 32'h44);
        check("recap_ack", 32'(o_rx_ack), 32'd1);
        i_rx_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
